// File: rtl/os_acc_drain.sv
// os_acc_drain: snapshot a row of output-stationary PE accumulators on CAPTURE,
// pulse a clear back to the row, then stream requantized words out one per
// valid/ready handshake, PE 0 first.
// Optional build macro ACC_DRAIN_ROUND_EN: round half up before the shift.

// Per-lane requantizer: unsigned right shift with saturation to OUT_W bits.
module os_acc_drain_rq #(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 8
) (
  input  logic [ACC_W-1:0] a,
  output logic [OUT_W-1:0] q
);
  localparam logic [ACC_W:0] MAX_V = (ACC_W+1)'((1 << OUT_W) - 1);

  logic [ACC_W:0] s;

`ifdef ACC_DRAIN_ROUND_EN
  // One extra bit keeps the rounding add from wrapping near full scale.
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT-1);
  logic [ACC_W:0] sum;
  assign sum = {1'b0, a} + HALF;
  assign s   = sum >> SHIFT;
`else
  assign s   = {1'b0, a} >> SHIFT;
`endif

  // Clamp anything that does not fit the output word.
  always_comb begin
    q = s[OUT_W-1:0];
    if (s > MAX_V) q = '1;
  end
endmodule

module os_acc_drain #(
  parameter int N_PE  = 8,
  parameter int ACC_W = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 8,
  parameter int IDX_W = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_PE*ACC_W-1:0] ACC_IN,
  input  logic                  CAPTURE,
  output logic                  ACC_CLR_N,
  output logic [OUT_W-1:0]      OUT_DATA,
  output logic [IDX_W-1:0]      OUT_IDX,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVERRUN
);
  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PE - 1);

  // Requantized view of the live accumulators; only consumed at CAPTURE.
  logic [N_PE-1:0][OUT_W-1:0] rq_in;

  for (genvar k = 0; k < N_PE; k++) begin : g_lane
    os_acc_drain_rq #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rq (
      .a (ACC_IN[k*ACC_W +: ACC_W]),
      .q (rq_in[k])
    );
  end

  state_t                     state_q, state_d;
  // Shadow holds the already-requantized words, so the drain side never
  // needs the raw accumulators again.
  logic [N_PE-1:0][OUT_W-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [OUT_W-1:0]           data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       done_q, done_d;
  logic                       ovr_q, ovr_d;
  logic                       clr_n_q, clr_n_d;
  logic [IDX_W-1:0]           idx_nxt;

  assign idx_nxt = idx_q + 1'b1;

  // Next-state: capture in IDLE, advance one word per handshake in SEND.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    ovr_d    = ovr_q;
    clr_n_d  = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (CAPTURE) begin
          shadow_d = rq_in;
          clr_n_d  = 1'b0;
          idx_d    = '0;
          data_d   = rq_in[0];
          valid_d  = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        // The row is still being drained; a new snapshot would lose words.
        if (CAPTURE) ovr_d = 1'b1;
        if (OUT_READY) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d  = idx_nxt;
            data_d = shadow_q[idx_nxt];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      clr_n_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      clr_n_q  <= clr_n_d;
    end
  end

  assign ACC_CLR_N = clr_n_q;
  assign OUT_DATA  = data_q;
  assign OUT_IDX   = idx_q;
  assign OUT_VALID = valid_q;
  assign BUSY      = (state_q == SEND);
  assign DONE      = done_q;
  assign OVERRUN   = ovr_q;
endmodule

// File: tb/tb_os_acc_drain.sv
// Scoreboard bench for os_acc_drain: stimulus pushes hand-computed words,
// a negedge monitor pops and compares on every handshake. A second instance
// with SHIFT=4 exercises saturation.
module tb_os_acc_drain;
  localparam int N_PE = 8;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [N_PE*16-1:0]   ACC_IN;
  logic                 CAPTURE;
  logic                 OUT_READY;
  logic                 ACC_CLR_N, OUT_VALID, BUSY, DONE, OVERRUN;
  logic [7:0]           OUT_DATA;
  logic [2:0]           OUT_IDX;
  logic                 s_clr_n, s_valid, s_busy, s_done, s_ovr;
  logic [7:0]           s_data;
  logic [2:0]           s_idx;

  always #5 CLK = ~CLK;

  os_acc_drain u_dut (
    .CLK(CLK), .RST(RST), .ACC_IN(ACC_IN), .CAPTURE(CAPTURE),
    .ACC_CLR_N(ACC_CLR_N), .OUT_DATA(OUT_DATA), .OUT_IDX(OUT_IDX),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .BUSY(BUSY),
    .DONE(DONE), .OVERRUN(OVERRUN)
  );

  os_acc_drain #(.SHIFT(4)) u_sat (
    .CLK(CLK), .RST(RST), .ACC_IN(ACC_IN), .CAPTURE(CAPTURE),
    .ACC_CLR_N(s_clr_n), .OUT_DATA(s_data), .OUT_IDX(s_idx),
    .OUT_VALID(s_valid), .OUT_READY(OUT_READY), .BUSY(s_busy),
    .DONE(s_done), .OVERRUN(s_ovr)
  );

  typedef struct packed { logic [2:0] idx; logic [7:0] data; } word_t;
  word_t q[$];
  word_t qs[$];
  bit    sat_chk = 1'b0;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    clr_cnt = 0, busy_cnt = 0, done_cnt = 0;

`ifdef ACC_DRAIN_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop on every handshake, and check words hold while stalled.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  logic [2:0] prev_idx   = '0;
  always @(negedge CLK) begin
    if (RST && OUT_VALID && OUT_READY) begin
      if (q.size() == 0) chk("unexpected_word_idx", int'(OUT_IDX), 99);
      else begin
        word_t e;
        e = q.pop_front();
        chk("word_idx", int'(OUT_IDX), int'(e.idx));
        chk("word_data", int'(OUT_DATA), int'(e.data));
      end
    end
    if (RST && prev_stall) begin
      chk("stall_hold_idx", int'(OUT_IDX), int'(prev_idx));
      chk("stall_hold_data", int'(OUT_DATA), int'(prev_data));
    end
    if (sat_chk && RST && s_valid && OUT_READY) begin
      if (qs.size() == 0) chk("unexpected_sat_word", int'(s_idx), 99);
      else begin
        word_t e;
        e = qs.pop_front();
        chk("sat_idx", int'(s_idx), int'(e.idx));
        chk("sat_data", int'(s_data), int'(e.data));
      end
    end
    prev_stall <= RST && OUT_VALID && !OUT_READY;
    prev_data  <= OUT_DATA;
    prev_idx   <= OUT_IDX;
  end

  // Event counters sampled mid-cycle.
  always @(negedge CLK) begin
    if (!ACC_CLR_N) clr_cnt  <= clr_cnt + 1;
    if (BUSY)       busy_cnt <= busy_cnt + 1;
    if (DONE)       done_cnt <= done_cnt + 1;
  end

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic set_acc(input int k, input logic [15:0] v);
    ACC_IN[k*16 +: 16] = v;
  endtask

  task automatic load_basic;
    for (int k = 0; k < N_PE; k++) set_acc(k, 16'(16'h0100 * (k + 1)));
  endtask

  task automatic push(input int idx, input int data);
    word_t w;
    w.idx = 3'(idx); w.data = 8'(data);
    q.push_back(w);
  endtask

  task automatic push_basic;
    for (int k = 0; k < N_PE; k++) push(k, k + 1);
  endtask

  task automatic do_capture;
    CAPTURE = 1'b1; tick; CAPTURE = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (BUSY && n < 100) begin tick; n++; end
    chk("drain_finished", int'(BUSY), 0);
    tick;
  endtask

  int c0, b0, d0, n;

  initial begin
    RST = 1'b0; ACC_IN = '0; CAPTURE = 1'b0; OUT_READY = 1'b0;
    tick; tick;
    chk("rst_valid", int'(OUT_VALID), 0);
    chk("rst_data",  int'(OUT_DATA), 0);
    chk("rst_idx",   int'(OUT_IDX), 0);
    chk("rst_busy",  int'(BUSY), 0);
    chk("rst_done",  int'(DONE), 0);
    chk("rst_ovr",   int'(OVERRUN), 0);
    chk("rst_clr_n", int'(ACC_CLR_N), 1);
    RST = 1'b1; tick;

    // Basic drain with ready held high; ACC_IN scrambled after the snapshot.
    load_basic; push_basic; OUT_READY = 1'b1;
    c0 = clr_cnt; b0 = busy_cnt; d0 = done_cnt;
    do_capture;
    chk("first_word_valid", int'(OUT_VALID), 1);
    chk("clr_low_after_capture", int'(ACC_CLR_N), 0);
    for (int k = 0; k < N_PE; k++) set_acc(k, 16'hAAAA);
    wait_idle;
    chk("basic_clr_cycles",  clr_cnt - c0, 1);
    chk("basic_busy_cycles", busy_cnt - b0, 8);
    chk("basic_done_pulses", done_cnt - d0, 1);
    chk("basic_no_overrun",  int'(OVERRUN), 0);

    // Backpressure: ready pattern 1,0,0 repeating.
    load_basic; push_basic;
    do_capture;
    n = 0;
    while (BUSY && n < 100) begin OUT_READY = (n % 3 == 0); tick; n++; end
    chk("bp_finished", int'(BUSY), 0);
    OUT_READY = 1'b1; tick;

    // Saturation on the SHIFT=4 instance; same vector on the main one.
    ACC_IN = '0; set_acc(0, 16'h1234); set_acc(1, 16'h00F0);
    sat_chk = 1'b1;
    begin
      word_t w;
      for (int k = 0; k < N_PE; k++) begin
        w.idx = 3'(k);
        w.data = (k == 0) ? 8'hFF : (k == 1) ? 8'h0F : 8'h00;
        qs.push_back(w);
      end
    end
    push(0, 8'h12); push(1, RND ? 8'h01 : 8'h00);
    for (int k = 2; k < N_PE; k++) push(k, 0);
    do_capture; wait_idle;
    sat_chk = 1'b0;
    chk("sat_queue_empty", qs.size(), 0);

    // Rounding vs truncation; full scale saturates in both builds.
    ACC_IN = '0;
    set_acc(0, 16'h01FF); set_acc(1, 16'h0180); set_acc(2, 16'h017F); set_acc(3, 16'hFFFF);
    push(0, RND ? 2 : 1); push(1, RND ? 2 : 1); push(2, 1); push(3, 8'hFF);
    for (int k = 4; k < N_PE; k++) push(k, 0);
    do_capture; wait_idle;

    // Overrun at OUT_IDX=3, then a capture in the DONE cycle.
    load_basic; push_basic;
    c0 = clr_cnt;
    do_capture;
    n = 0;
    while (OUT_IDX != 3 && n < 20) begin tick; n++; end
    chk("reach_idx3", int'(OUT_IDX), 3);
    for (int k = 0; k < N_PE; k++) set_acc(k, 16'h7700);
    CAPTURE = 1'b1; tick; CAPTURE = 1'b0;
    chk("ovr_set", int'(OVERRUN), 1);
    n = 0;
    while (!DONE && n < 20) begin tick; n++; end
    chk("done_seen", int'(DONE), 1);
    for (int k = 0; k < N_PE; k++) begin
      set_acc(k, 16'(16'h0A00 + 16'h0100 * k));
      push(k, 8'h0A + k);
    end
    chk("ovr_no_clr", clr_cnt - c0, 1);
    CAPTURE = 1'b1; tick; CAPTURE = 1'b0;
    chk("done_cycle_capture_busy", int'(BUSY), 1);
    wait_idle;
    chk("ovr_clr_total", clr_cnt - c0, 2);
    chk("ovr_sticky", int'(OVERRUN), 1);

    // Reset in the middle of a drain.
    load_basic;
    for (int k = 0; k < 5; k++) push(k, k + 1);
    do_capture;
    n = 0;
    while (OUT_IDX != 5 && n < 20) begin tick; n++; end
    chk("reach_idx5", int'(OUT_IDX), 5);
    RST = 1'b0; #1;
    chk("midrst_valid", int'(OUT_VALID), 0);
    chk("midrst_busy",  int'(BUSY), 0);
    chk("midrst_ovr",   int'(OVERRUN), 0);
    chk("midrst_idx",   int'(OUT_IDX), 0);
    chk("midrst_queue", q.size(), 0);
    tick; RST = 1'b1; tick;
    for (int k = 0; k < N_PE; k++) begin
      set_acc(k, 16'(16'h2000 + 16'h1100 * k));
      push(k, 8'h20 + 8'h11 * k);
    end
    do_capture; wait_idle;

    chk("final_queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/os_acc_drain.md
Name: os_acc_drain

Overview:
- Downstream drain stage for one row of output-stationary MAC PEs; each PE exposes an accumulated 16-bit unsigned MAC_OUT.
- On a CAPTURE strobe, snapshots all row accumulators into shadow registers and pulses a clear back to the row.
- Requantizes each value (right shift with saturation) and streams the row out one word per handshake, PE 0 first.
- Shadowing lets the PE row start the next tile while the previous tile drains.

Parameters:
- N_PE, 8, number of PEs (accumulators) in the row; >=2
- ACC_W, 16, accumulator width (matches PE MAC_OUT)
- OUT_W, 8, output word width
- SHIFT, 8, requantization right shift; 1..ACC_W-1
- IDX_W, 3, index width; must satisfy 2**IDX_W >= N_PE

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-low
- ACC_IN  in  N_PE*ACC_W  flattened PE accumulators; PE k at bits [k*ACC_W +: ACC_W]
- CAPTURE  in  1  single-cycle strobe: row accumulation complete, take snapshot
- ACC_CLR_N  out  1  registered active-low clear to PE row accumulators
- OUT_DATA  out  OUT_W  requantized word
- OUT_IDX  out  IDX_W  PE index of OUT_DATA
- OUT_VALID  out  1  OUT_DATA/OUT_IDX valid
- OUT_READY  in  1  downstream accepts word
- BUSY  out  1  drain in progress (state SEND)
- DONE  out  1  one-cycle pulse after last word accepted
- OVERRUN  out  1  sticky: CAPTURE arrived while BUSY

Behaviour:
- Reset (RST=0, async): state IDLE; OUT_VALID=0, OUT_DATA=0, OUT_IDX=0, BUSY=0, DONE=0, OVERRUN=0, ACC_CLR_N=1; shadow registers=0.
- FSM states: IDLE and SEND.
- IDLE, CAPTURE=1 at edge t:
  - Latch all N_PE accumulators into shadow.
  - ACC_CLR_N=0 for exactly the one cycle after edge t, back to 1 at edge t+1.
  - Go to SEND with OUT_IDX=0, OUT_VALID=1, OUT_DATA=rq(shadow[0]), all registered at edge t. First word is visible 1 cycle after CAPTURE.
- SEND:
  - OUT_VALID held at 1. OUT_DATA/OUT_IDX remain stable until accepted.
  - Handshake = OUT_VALID & OUT_READY at a rising edge.
  - On handshake with OUT_IDX<N_PE-1: OUT_IDX+1, OUT_DATA=rq(shadow[OUT_IDX+1]).
  - On handshake with OUT_IDX==N_PE-1: OUT_VALID=0, OUT_IDX=0, DONE=1 for one cycle, return to IDLE.
  - OUT_READY=0 stalls indefinitely; no word is dropped or repeated.
- Throughput: with OUT_READY held at 1, N_PE words on N_PE consecutive cycles. A new CAPTURE is accepted in the cycle DONE is high (state already IDLE).
- CAPTURE while in SEND:
  - Ignored: shadow unchanged, no ACC_CLR_N pulse.
  - OVERRUN set; it stays set until reset.
- rq(a), unsigned arithmetic:
  - s = a >> SHIFT (logical shift).
  - If s > 2**OUT_W-1, result = 2**OUT_W-1 (saturate); else result = s[OUT_W-1:0].
- BUSY = 1 exactly when state is SEND.
- Reset mid-drain: all outputs return to reset values immediately; remaining words are discarded; the next CAPTURE starts from index 0.
- ACC_IN is sampled only at the CAPTURE edge; changes at any other time have no effect.

Optional Feature:
- Macro: ACC_DRAIN_ROUND_EN.
- Defined: round half up before the shift. s = (a + 2**(SHIFT-1)) >> SHIFT, with the sum computed in ACC_W+1 bits (no wrap), then saturated as above.
- Undefined: truncating shift only, as specified in Behaviour. No other difference; port list identical in both builds.

Test Plan:
- Reset/basic drain: reset, ACC_IN PE k = 0x0100*(k+1), CAPTURE, OUT_READY=1 -> ACC_CLR_N low exactly 1 cycle; words 0x01..0x08 with OUT_IDX 0..7 on 8 consecutive cycles; DONE pulses once; BUSY high 8 cycles.
- Backpressure: same data, OUT_READY toggled 1,0,0,1,... -> OUT_DATA/OUT_IDX held while not ready; sequence 0x01..0x08 complete, no duplicates.
- Saturation (SHIFT=4): PE0 acc=0x1234, PE1=0x00F0 -> 0xFF, then 0x0F.
- Rounding: PE0 acc=0x01FF, PE1=0x0180, PE2=0x017F -> undefined: 0x01,0x01,0x01; with ACC_DRAIN_ROUND_EN: 0x02,0x02,0x01; acc=0xFFFF -> 0xFF in both builds.
- Overrun: CAPTURE again at OUT_IDX=3 with changed ACC_IN -> original words continue unchanged, no ACC_CLR_N pulse, OVERRUN=1 and stays 1; CAPTURE in the DONE cycle is accepted normally.
- Reset mid-op: RST low at OUT_IDX=5 -> OUT_VALID=0, BUSY=0, OVERRUN=0 immediately; next CAPTURE drains from OUT_IDX=0 with new data.
